multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle instruction sequencer for the 4-bit-opcode datapath.
- Fetches instruction words over a req/ack instruction port.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, issuing per-phase datapath controls: register write enable, ALU op, memory read/write, 2-bit mux select.
- Sits between the instruction/data memory handshakes and the register file / ALU / operand-mux datapath.

Parameters:
ADDR_W, 8, program counter and instruction-address width
INSTR_W, 16, instruction word width; opcode = instr[INSTR_W-1 -: 4], jump target = instr[ADDR_W-1:0]
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  leave IDLE or HALT and begin fetching at pc 0
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address (= pc)
imem_ack  in  1  fetch complete; instr_rdata valid this cycle
instr_rdata  in  INSTR_W  fetched instruction
dmem_req  out  1  data memory access request
dmem_ack  in  1  data access complete
reg_write_enable  out  1  register file write strobe
alu_op  out  1  0 = add, 1 = sub
mem_read  out  1  data read qualifier
mem_write  out  1  data write qualifier
mux_sel  out  2  operand/writeback mux select
ir  out  INSTR_W  current instruction register
pc  out  ADDR_W  program counter
busy  out  1  state not IDLE and not HALT
halted  out  1  state == HALT
retire_cnt  out  CNT_W  retired instruction count

Behaviour:
- Reset (async, rst_n=0): state IDLE, pc 0, ir 0, retire_cnt 0, all outputs 0. An in-flight request drops immediately; no completion is recorded.
- Opcodes:
  - 0000 ADD: alu_op 0, mux 00, writes reg
  - 0001 SUB: alu_op 1, mux 01, writes reg
  - 0010 LOAD: mux 10, mem_read, writes reg
  - 0011 STORE: mux 10, mem_write
  - 0100 JUMP
  - 1111 HALT
  - all other opcodes: NOP
- All outputs are Moore: a function of state and ir only.
- IDLE: start=1 -> pc<=0, FETCH.
- FETCH: imem_req=1, imem_addr=pc, held until imem_ack. On ack: ir<=instr_rdata, pc<=pc+1 (wraps mod 2^ADDR_W), -> DECODE.
- DECODE (1 cycle):
  - HALT -> HALT state.
  - JUMP -> pc<=target, retire, -> FETCH.
  - NOP -> retire, -> FETCH.
  - ADD/SUB/LOAD/STORE -> EXEC.
- EXEC (1 cycle): ADD/SUB -> WB; LOAD/STORE -> MEM.
- MEM: dmem_req=1 plus mem_read (LOAD) or mem_write (STORE), held until dmem_ack. On ack: LOAD -> WB; STORE -> retire, FETCH.
- WB (1 cycle): reg_write_enable=1, retire, -> FETCH.
- HALT: halted=1, no requests. start=1 -> pc<=0, FETCH. HALT does not retire.
- Control timing:
  - alu_op and mux_sel valid from EXEC through MEM/WB of the same instruction, 0 otherwise.
  - reg_write_enable asserts only in WB.
  - mem_read/mem_write assert only in MEM.
- Latency with zero-wait ack:
  - ADD/SUB: 4 cycles, FETCH to WB inclusive.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - JUMP/NOP: 2 cycles.
- Boundaries:
  - imem_ack/dmem_ack outside their wait state are ignored.
  - start outside IDLE/HALT is ignored.
  - pc 0xFF fetch -> pc 0x00.
  - retire_cnt wraps at 2^CNT_W.
  - Unbounded wait states; no timeout.

Decomposition:
- Shared package seq_pkg:
  - opcode enum (OP_ADD, OP_SUB, OP_LOAD, OP_STORE, OP_JUMP, OP_HALT)
  - state enum (S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT)
  - packed struct ctrl_t {reg_we, alu_op, mem_rd, mem_wr, mux_sel[1:0]}
  - OPCODE_W=4
- Sub-module seq_decode: combinational opcode -> ctrl_t plus class flags (is_jump, is_halt, is_mem, is_nop). The FSM gates ctrl_t by state.

Test Plan:
- Reset, then start; imem returns 0x0000 (ADD) with ack on first req cycle -> imem_addr 0; WB in cycle 4 with reg_write_enable=1, alu_op=0, mux_sel=00; retire_cnt=1, pc=1.
- Fetch 0x2xxx (LOAD) with dmem_ack delayed 3 cycles -> mem_read and dmem_req held 3 cycles, then WB with reg_write_enable=1, mux_sel=10; STORE 0x3xxx -> mem_write, no reg_write_enable, direct return to FETCH.
- JUMP 0x4042 at pc 5 -> next imem_addr 0x42, retire_cnt +1, no datapath strobes.
- Program pc 0xFF holding SUB 0x1000 -> alu_op=1, mux_sel=01 in EXEC/WB; next fetch addr 0x00.
- HALT 0xF000 -> halted=1, busy=0, no req for 10 cycles, retire_cnt unchanged; start -> imem_addr 0.
- rst_n low during MEM with dmem_req=1 -> all outputs 0 immediately, state IDLE, retire_cnt 0; a later dmem_ack has no effect.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types for the multi-cycle sequencer: opcodes, FSM states and the datapath control bundle.
// Purely declarative; no timing or handshake of its own.
package seq_pkg;

  localparam int OPCODE_W = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD   = 4'h0,
    OP_SUB   = 4'h1,
    OP_LOAD  = 4'h2,
    OP_STORE = 4'h3,
    OP_JUMP  = 4'h4,
    OP_HALT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef struct packed {
    logic       reg_we;
    logic       alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mux_sel;
  } ctrl_t;

endpackage

// File: rtl/seq_decode.sv
// Opcode decoder: raw datapath controls plus instruction-class flags, combinational (0 cycles).
// No handshake; the sequencer FSM gates these controls by phase.
module seq_decode
  import seq_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                is_jump,
  output logic                is_halt,
  output logic                is_mem,
  output logic                is_nop
);

  always_comb begin
    ctrl    = '0;
    is_jump = 1'b0;
    is_halt = 1'b0;
    is_mem  = 1'b0;
    is_nop  = 1'b0;
    case (opcode)
      OP_ADD: begin
        ctrl.reg_we  = 1'b1;
        ctrl.mux_sel = 2'b00;
      end
      OP_SUB: begin
        ctrl.reg_we  = 1'b1;
        ctrl.alu_op  = 1'b1;
        ctrl.mux_sel = 2'b01;
      end
      OP_LOAD: begin
        ctrl.reg_we  = 1'b1;
        ctrl.mem_rd  = 1'b1;
        ctrl.mux_sel = 2'b10;
        is_mem       = 1'b1;
      end
      OP_STORE: begin
        ctrl.mem_wr  = 1'b1;
        ctrl.mux_sel = 2'b10;
        is_mem       = 1'b1;
      end
      OP_JUMP: is_jump = 1'b1;
      OP_HALT: is_halt = 1'b1;
      default: is_nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer; ADD/SUB/STORE 4 cycles, LOAD 5, JUMP/NOP 2 with zero-wait acks.
// FETCH and MEM hold their request until ack with no timeout; outputs are registered from next state/ir.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] instr_rdata,
  output logic               dmem_req,
  input  logic               dmem_ack,
  output logic               reg_write_enable,
  output logic               alu_op,
  output logic               mem_read,
  output logic               mem_write,
  output logic [1:0]         mux_sel,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               halted,
  output logic [CNT_W-1:0]   retire_cnt
);

  state_e             state, state_nxt;
  logic [INSTR_W-1:0] ir_nxt;
  logic [ADDR_W-1:0]  pc_nxt;
  logic               retire;
  logic               ex_phase_nxt;

  ctrl_t ctrl_cur, ctrl_nxt;
  logic  cur_jump, cur_halt, cur_mem, cur_nop;
  logic  nxt_jump, nxt_halt, nxt_mem, nxt_nop;

  // Current ir steers the FSM; next ir feeds the registered control outputs.
  seq_decode u_dec_cur (
    .opcode (ir[INSTR_W-1 -: OPCODE_W]),
    .ctrl   (ctrl_cur),
    .is_jump(cur_jump),
    .is_halt(cur_halt),
    .is_mem (cur_mem),
    .is_nop (cur_nop)
  );

  seq_decode u_dec_nxt (
    .opcode (ir_nxt[INSTR_W-1 -: OPCODE_W]),
    .ctrl   (ctrl_nxt),
    .is_jump(nxt_jump),
    .is_halt(nxt_halt),
    .is_mem (nxt_mem),
    .is_nop (nxt_nop)
  );

  assign imem_addr = pc;

  always_comb begin
    state_nxt = state;
    ir_nxt    = ir;
    pc_nxt    = pc;
    retire    = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_nxt    = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (imem_ack) begin
          ir_nxt    = instr_rdata;
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (cur_halt) begin
          state_nxt = S_HALT;
        end else if (cur_jump) begin
          pc_nxt    = ir[ADDR_W-1:0];
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (cur_nop) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: state_nxt = cur_mem ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          if (ctrl_cur.mem_rd) begin
            state_nxt = S_WB;
          end else begin
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end
        end
      end
      S_WB: begin
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ex_phase_nxt = (state_nxt == S_EXEC) || (state_nxt == S_MEM) || (state_nxt == S_WB);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      ir               <= '0;
      pc               <= '0;
      retire_cnt       <= '0;
      imem_req         <= 1'b0;
      dmem_req         <= 1'b0;
      reg_write_enable <= 1'b0;
      alu_op           <= 1'b0;
      mem_read         <= 1'b0;
      mem_write        <= 1'b0;
      mux_sel          <= 2'b00;
      busy             <= 1'b0;
      halted           <= 1'b0;
    end else begin
      state <= state_nxt;
      ir    <= ir_nxt;
      pc    <= pc_nxt;
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
      imem_req         <= (state_nxt == S_FETCH);
      dmem_req         <= (state_nxt == S_MEM);
      reg_write_enable <= (state_nxt == S_WB) && ctrl_nxt.reg_we;
      mem_read         <= (state_nxt == S_MEM) && ctrl_nxt.mem_rd;
      mem_write        <= (state_nxt == S_MEM) && ctrl_nxt.mem_wr;
      alu_op           <= ex_phase_nxt && ctrl_nxt.alu_op;
      mux_sel          <= ex_phase_nxt ? ctrl_nxt.mux_sel : 2'b00;
      busy             <= (state_nxt != S_IDLE) && (state_nxt != S_HALT);
      halted           <= (state_nxt == S_HALT);
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: hand-sequenced program with cycle-exact expectations.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] instr_rdata;
  logic        dmem_req;
  logic        dmem_ack;
  logic        reg_write_enable;
  logic        alu_op;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mux_sel;
  logic [15:0] ir;
  logic [7:0]  pc;
  logic        busy;
  logic        halted;
  logic [15:0] retire_cnt;

  int n_chk = 0;
  int n_err = 0;

  multicycle_sequencer #(.ADDR_W(8), .INSTR_W(16), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .instr_rdata     (instr_rdata),
    .dmem_req        (dmem_req),
    .dmem_ack        (dmem_ack),
    .reg_write_enable(reg_write_enable),
    .alu_op          (alu_op),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mux_sel         (mux_sel),
    .ir              (ir),
    .pc              (pc),
    .busy            (busy),
    .halted          (halted),
    .retire_cnt      (retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects FETCH at addr; returns the instruction with a zero-wait ack, leaves DUT in DECODE.
  task automatic serve_fetch(input logic [7:0] addr, input logic [15:0] instr);
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", {24'd0, imem_addr}, {24'd0, addr});
    imem_ack    = 1'b1;
    instr_rdata = instr;
    tick();
    imem_ack    = 1'b0;
    instr_rdata = 16'hDEAD;
  endtask

  task automatic chk_no_strobes(input string tag);
    chk({tag, "_we"}, {31'd0, reg_write_enable}, 32'd0);
    chk({tag, "_dreq"}, {31'd0, dmem_req}, 32'd0);
    chk({tag, "_mux"}, {30'd0, mux_sel}, 32'd0);
    chk({tag, "_alu"}, {31'd0, alu_op}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; instr_rdata = '0;
    #3;
    chk("rst_pc", {24'd0, pc}, 32'd0);
    chk("rst_ir", {16'd0, ir}, 32'd0);
    chk("rst_cnt", {16'd0, retire_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ireq", {31'd0, imem_req}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_ireq", {31'd0, imem_req}, 32'd0);

    // ADD at pc 0
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", {31'd0, busy}, 32'd1);
    serve_fetch(8'h00, 16'h0000);
    chk("add_dec_pc", {24'd0, pc}, 32'd1);
    chk("add_dec_ireq", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b1; instr_rdata = 16'hF000;   // stray ack outside FETCH
    tick();
    imem_ack = 1'b0;
    chk("add_ex_ir", {16'd0, ir}, 32'h0000);
    chk("add_ex_we", {31'd0, reg_write_enable}, 32'd0);
    tick();
    chk("add_wb_we", {31'd0, reg_write_enable}, 32'd1);
    chk("add_wb_alu", {31'd0, alu_op}, 32'd0);
    chk("add_wb_mux", {30'd0, mux_sel}, 32'd0);
    chk("add_wb_cnt", {16'd0, retire_cnt}, 32'd0);
    tick();
    chk("add_cnt", {16'd0, retire_cnt}, 32'd1);
    chk("add_pc", {24'd0, pc}, 32'd1);

    // LOAD at pc 1, dmem ack on third MEM cycle
    serve_fetch(8'h01, 16'h2ABC);
    tick();
    chk("ld_ex_mux", {30'd0, mux_sel}, 32'd2);
    chk("ld_ex_rd", {31'd0, mem_read}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ld_mem_dreq", {31'd0, dmem_req}, 32'd1);
      chk("ld_mem_rd", {31'd0, mem_read}, 32'd1);
      chk("ld_mem_we", {31'd0, reg_write_enable}, 32'd0);
      if (i == 2) dmem_ack = 1'b1;
      tick();
    end
    dmem_ack = 1'b0;
    chk("ld_wb_we", {31'd0, reg_write_enable}, 32'd1);
    chk("ld_wb_mux", {30'd0, mux_sel}, 32'd2);
    chk("ld_wb_rd", {31'd0, mem_read}, 32'd0);
    chk("ld_wb_dreq", {31'd0, dmem_req}, 32'd0);
    tick();
    chk("ld_cnt", {16'd0, retire_cnt}, 32'd2);

    // STORE at pc 2
    serve_fetch(8'h02, 16'h3123);
    tick(); tick();
    chk("st_mem_wr", {31'd0, mem_write}, 32'd1);
    chk("st_mem_rd", {31'd0, mem_read}, 32'd0);
    chk("st_mem_we", {31'd0, reg_write_enable}, 32'd0);
    dmem_ack = 1'b1; tick(); dmem_ack = 1'b0;
    chk("st_fetch", {31'd0, imem_req}, 32'd1);
    chk("st_wr_off", {31'd0, mem_write}, 32'd0);
    chk("st_cnt", {16'd0, retire_cnt}, 32'd3);

    // NOPs at pc 3 and 4
    serve_fetch(8'h03, 16'h7000);
    chk_no_strobes("nop_dec");
    tick();
    chk("nop_cnt", {16'd0, retire_cnt}, 32'd4);
    serve_fetch(8'h04, 16'h8000);
    tick();

    // JUMP at pc 5 with a stray start that must be ignored
    serve_fetch(8'h05, 16'h4042);
    chk_no_strobes("jmp_dec");
    start = 1'b1; tick(); start = 1'b0;
    chk("jmp_addr", {24'd0, imem_addr}, 32'h42);
    chk("jmp_cnt", {16'd0, retire_cnt}, 32'd6);

    // JUMP to 0xFF, SUB there, fetch wraps to 0x00
    serve_fetch(8'h42, 16'h40FF);
    tick();
    serve_fetch(8'hFF, 16'h1000);
    chk("sub_dec_pc", {24'd0, pc}, 32'h00);
    tick();
    chk("sub_ex_alu", {31'd0, alu_op}, 32'd1);
    chk("sub_ex_mux", {30'd0, mux_sel}, 32'd1);
    tick();
    chk("sub_wb_alu", {31'd0, alu_op}, 32'd1);
    chk("sub_wb_mux", {30'd0, mux_sel}, 32'd1);
    chk("sub_wb_we", {31'd0, reg_write_enable}, 32'd1);
    tick();
    chk("sub_cnt", {16'd0, retire_cnt}, 32'd8);

    // HALT at pc 0
    serve_fetch(8'h00, 16'hF000);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt_halted", {31'd0, halted}, 32'd1);
      chk("halt_busy", {31'd0, busy}, 32'd0);
      chk("halt_ireq", {31'd0, imem_req}, 32'd0);
      tick();
    end
    chk("halt_cnt", {16'd0, retire_cnt}, 32'd8);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_ireq", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", {24'd0, imem_addr}, 32'd0);
    chk("restart_halted", {31'd0, halted}, 32'd0);

    // LOAD into MEM, then async reset mid-cycle
    serve_fetch(8'h00, 16'h2000);
    tick(); tick();
    chk("pre_rst_dreq", {31'd0, dmem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dreq", {31'd0, dmem_req}, 32'd0);
    chk("arst_rd", {31'd0, mem_read}, 32'd0);
    chk("arst_mux", {30'd0, mux_sel}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_cnt", {16'd0, retire_cnt}, 32'd0);
    chk("arst_pc", {24'd0, pc}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    tick(); tick();
    dmem_ack = 1'b0;
    chk("post_rst_we", {31'd0, reg_write_enable}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_ireq", {31'd0, imem_req}, 32'd0);
    chk("post_rst_cnt", {16'd0, retire_cnt}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
